piezo_tone_player: RTL and testbench

Parametrised successor to the single-tone piezo driver: a queued tone sequencer for the piezo buzzer. The game/menu controllers push notes (half-period, duration) through a valid/ready port into an internal FIFO. The block plays each note as a square wave for its duration, inserts a fixed silent gap, then plays the next note. It supports rests, pause, flush, and per-note completion pulses. It sits between the sound-effect controllers and the board piezo pin.

---
 rtl/piezo_tone_player_pkg.sv | 26 ++
 rtl/piezo_tone_player_tone_fifo.sv | 65 ++++++
 rtl/piezo_tone_player.sv | 195 +++++++++++++++++++
 tb/tb_piezo_tone_player.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_tone_player_pkg.sv
// Shared definitions for the queued piezo tone sequencer: FSM encoding and
// elaboration-time helpers for the millisecond timebase.
package piezo_tone_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } play_state_t;

  // Clock cycles per millisecond tick.
  function automatic int ms_cyc(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int width_of(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/piezo_tone_player_tone_fifo.sv
// First-word fall-through note FIFO: head entry is readable whenever !empty.
module tone_fifo
  import piezo_tone_player_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == (AW + 1)'(0));
  assign level     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  // Note storage write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW + 1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/piezo_tone_player.sv
// Queued tone sequencer: plays FIFO'd (half-period, duration) notes as square
// waves on the piezo pin, with a silent gap and a done pulse after each note.
module piezo_tone_player
  import piezo_tone_player_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 32,
  parameter int DUR_W  = 16,
  parameter int DEPTH  = 8,
  parameter int GAP_MS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [CNT_W-1:0]         i_half_period,
  input  logic [DUR_W-1:0]         i_dur_ms,
  output logic                     o_ready,
  input  logic                     i_play_en,
  input  logic                     i_flush,
  output logic                     o_piezo,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int MS_CYC = ms_cyc(CLK_HZ);
  localparam int PRE_W  = width_of(MS_CYC);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int NOTE_W = CNT_W + DUR_W;
  localparam bit HAS_GAP = (GAP_MS > 0);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = HAS_GAP ? DUR_W'(GAP_MS - 1) : DUR_W'(0);

  typedef struct packed {
    logic [CNT_W-1:0] half_period;
    logic [DUR_W-1:0] dur_ms;
  } note_t;

  note_t              push_note_s;
  note_t              head_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               run_s;
  logic               tick_last_s;
  logic               play_last_s;
  logic               gap_last_s;
  logic               done_s;
  logic [LVL_W-1:0]   level_s;

  play_state_t        state_r;
  logic [CNT_W-1:0]   half_r;
  logic [CNT_W-1:0]   tone_cnt_r;
  logic [DUR_W-1:0]   dur_r;
  logic [DUR_W-1:0]   ms_cnt_r;
  logic [PRE_W-1:0]   pre_cnt_r;
  logic               piezo_r;

  assign o_ready     = !full_s && !i_flush;
  assign push_s      = i_valid && o_ready;
  assign push_note_s = '{half_period: i_half_period, dur_ms: i_dur_ms};

  tone_fifo #(
    .WIDTH (NOTE_W),
    .DEPTH (DEPTH)
  ) u_tone_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_note_s),
    .pop       (pop_s),
    .flush     (i_flush),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s)
  );

  // Pause gates the pin immediately; the registered phase is cleared behind it.
  assign o_piezo = piezo_r && i_play_en;
  assign o_busy  = (state_r != ST_IDLE);
  assign o_done  = done_s;
  assign o_level = level_s;

  // Pop request and end-of-note detection for the current cycle.
  always_comb begin
    pop_s       = 1'b0;
    done_s      = 1'b0;
    run_s       = i_play_en && !i_flush;
    tick_last_s = (pre_cnt_r == PRE_LAST);
    play_last_s = tick_last_s && (ms_cnt_r == (dur_r - DUR_W'(1)));
    gap_last_s  = tick_last_s && (ms_cnt_r == GAP_LAST);
    case (state_r)
      ST_IDLE: begin
        if (run_s && !empty_s) begin
          pop_s  = 1'b1;
          done_s = (head_s.dur_ms == DUR_W'(0)) && !HAS_GAP;
        end else begin
          pop_s  = 1'b0;
          done_s = 1'b0;
        end
      end
      ST_PLAY: done_s = run_s && play_last_s && !HAS_GAP;
      ST_GAP:  done_s = run_s && gap_last_s;
      default: done_s = 1'b0;
    endcase
  end

  // Sequencer FSM, note registers, tone and millisecond counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      half_r     <= CNT_W'(0);
      dur_r      <= DUR_W'(0);
      tone_cnt_r <= CNT_W'(0);
      pre_cnt_r  <= PRE_W'(0);
      ms_cnt_r   <= DUR_W'(0);
      piezo_r    <= 1'b0;
    end else if (i_flush) begin
      state_r    <= ST_IDLE;
      tone_cnt_r <= CNT_W'(0);
      pre_cnt_r  <= PRE_W'(0);
      ms_cnt_r   <= DUR_W'(0);
      piezo_r    <= 1'b0;
    end else if (!i_play_en) begin
      tone_cnt_r <= CNT_W'(0);
      piezo_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            half_r     <= head_s.half_period;
            dur_r      <= head_s.dur_ms;
            tone_cnt_r <= CNT_W'(0);
            pre_cnt_r  <= PRE_W'(0);
            ms_cnt_r   <= DUR_W'(0);
            piezo_r    <= 1'b0;
            if (head_s.dur_ms == DUR_W'(0)) begin
              state_r <= HAS_GAP ? ST_GAP : ST_IDLE;
            end else begin
              state_r <= ST_PLAY;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (play_last_s) begin
            state_r    <= HAS_GAP ? ST_GAP : ST_IDLE;
            tone_cnt_r <= CNT_W'(0);
            pre_cnt_r  <= PRE_W'(0);
            ms_cnt_r   <= DUR_W'(0);
            piezo_r    <= 1'b0;
          end else begin
            // A zero half-period is a rest: time runs, the pin stays low.
            if (half_r == CNT_W'(0)) begin
              tone_cnt_r <= CNT_W'(0);
              piezo_r    <= 1'b0;
            end else if (tone_cnt_r == (half_r - CNT_W'(1))) begin
              tone_cnt_r <= CNT_W'(0);
              piezo_r    <= !piezo_r;
            end else begin
              tone_cnt_r <= tone_cnt_r + CNT_W'(1);
            end
            if (tick_last_s) begin
              pre_cnt_r <= PRE_W'(0);
              ms_cnt_r  <= ms_cnt_r + DUR_W'(1);
            end else begin
              pre_cnt_r <= pre_cnt_r + PRE_W'(1);
            end
          end
        end
        ST_GAP: begin
          piezo_r <= 1'b0;
          if (gap_last_s) begin
            state_r   <= ST_IDLE;
            pre_cnt_r <= PRE_W'(0);
            ms_cnt_r  <= DUR_W'(0);
          end else if (tick_last_s) begin
            pre_cnt_r <= PRE_W'(0);
            ms_cnt_r  <= ms_cnt_r + DUR_W'(1);
          end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          piezo_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_tone_player.sv
// Self-checking bench for piezo_tone_player: directed test-plan scenarios plus
// randomized traffic, all compared against a note-timeline reference model.
module tb_piezo_tone_player;

  localparam int CLK_HZ  = 10000;
  localparam int CNT_W   = 16;
  localparam int DUR_W   = 8;
  localparam int DEPTH   = 8;
  localparam int GAP_MS  = 2;
  localparam int MS      = CLK_HZ / 1000;
  localparam int GAP_CYC = GAP_MS * MS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_valid = 1'b0;
  logic [CNT_W-1:0] i_half_period = '0;
  logic [DUR_W-1:0] i_dur_ms = '0;
  logic             i_play_en = 1'b0;
  logic             i_flush = 1'b0;
  logic             o_ready;
  logic             o_piezo;
  logic             o_busy;
  logic             o_done;
  logic [3:0]       o_level;

  always #5 clk = ~clk;

  piezo_tone_player #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W),
    .DUR_W  (DUR_W),
    .DEPTH  (DEPTH),
    .GAP_MS (GAP_MS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_half_period (i_half_period),
    .i_dur_ms      (i_dur_ms),
    .o_ready       (o_ready),
    .i_play_en     (i_play_en),
    .i_flush       (i_flush),
    .o_piezo       (o_piezo),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_level       (o_level)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: queue of notes and elapsed enabled cycles in the current note phase.
  int q_hp[$];
  int q_dur[$];
  int m_phase = 0;   // 0 idle, 1 sounding, 2 silent gap
  int m_hp = 0, m_dur = 0, m_el = 0, m_tone = 0;
  bit chk_on = 1'b0;
  int cyc = 0;

  int done_cnt, last_done_cyc, busy_fall_cyc, first_toggle_cyc, toggle_cnt;
  logic prev_busy, prev_piezo;

  task automatic clear_trackers();
    done_cnt = 0; last_done_cyc = -1; busy_fall_cyc = -1;
    first_toggle_cyc = -1; toggle_cnt = 0;
    prev_busy = o_busy; prev_piezo = o_piezo;
  endtask

  task automatic model_edge();
    bit will_push;
    if (!rst) begin
      q_hp.delete(); q_dur.delete();
      m_phase = 0; m_el = 0; m_tone = 0;
    end else if (i_flush) begin
      q_hp.delete(); q_dur.delete();
      m_phase = 0; m_el = 0; m_tone = 0;
    end else begin
      will_push = i_valid && (q_hp.size() < DEPTH);
      if (i_play_en) begin
        case (m_phase)
          0: if (q_hp.size() > 0) begin
               m_hp = q_hp.pop_front(); m_dur = q_dur.pop_front();
               m_el = 0; m_tone = 0;
               m_phase = (m_dur == 0) ? 2 : 1;
             end
          1: begin
               m_el++; m_tone++;
               if (m_el == m_dur * MS) begin m_phase = 2; m_el = 0; end
             end
          default: begin
               m_el++;
               if (m_el == GAP_CYC) begin m_phase = 0; m_el = 0; end
             end
        endcase
      end else begin
        m_tone = 0;
      end
      if (will_push) begin
        q_hp.push_back(int'(i_half_period)); q_dur.push_back(int'(i_dur_ms));
      end
    end
  endtask

  // One clock: compare at negedge against the model, then advance the model at posedge.
  task automatic tick();
    int e_piezo, e_done, e_ready, e_busy, e_level;
    @(negedge clk);
    e_ready = (q_hp.size() < DEPTH) && !i_flush;
    e_level = q_hp.size();
    e_busy  = (m_phase != 0);
    e_piezo = (m_phase == 1 && i_play_en && m_hp != 0) ? ((m_tone / m_hp) % 2) : 0;
    e_done  = (m_phase == 2 && i_play_en && !i_flush && m_el == GAP_CYC - 1);
    if (chk_on) begin
      check("ready", o_ready, e_ready);
      check("level", o_level, e_level);
      check("busy",  o_busy,  e_busy);
      check("piezo", o_piezo, e_piezo);
      check("done",  o_done,  e_done);
    end
    if (o_done) begin done_cnt++; last_done_cyc = cyc; end
    if (prev_busy && !o_busy) busy_fall_cyc = cyc;
    if (o_piezo != prev_piezo) begin
      toggle_cnt++;
      if (first_toggle_cyc < 0) first_toggle_cyc = cyc;
    end
    prev_busy = o_busy; prev_piezo = o_piezo;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic push_note(input int hp, input int dur);
    i_valid = 1'b1; i_half_period = CNT_W'(hp); i_dur_ms = DUR_W'(dur);
    tick();
    i_valid = 1'b0;
  endtask

  int c0;

  initial begin
    // Reset
    rst = 1'b0;
    tick(); tick();
    chk_on = 1'b1;
    check("rst_piezo", o_piezo, 0); check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);   check("rst_level", o_level, 0);
    check("rst_ready", o_ready, 1);
    rst = 1'b1; i_play_en = 1'b1;
    tick();

    // Single note hp=3 dur=2
    clear_trackers(); c0 = cyc;
    push_note(3, 2);
    repeat (45) tick();
    check("s1_done_cnt", done_cnt, 1);
    check("s1_done_cyc", last_done_cyc - c0, 41);
    check("s1_busy_fall", busy_fall_cyc - c0, 42);
    check("s1_first_toggle", first_toggle_cyc - c0, 5);
    check("s1_toggles", toggle_cnt, 6);

    // Rest then hp=2
    clear_trackers(); c0 = cyc;
    push_note(0, 1);
    push_note(2, 1);
    repeat (70) tick();
    check("s2_done_cnt", done_cnt, 2);
    check("s2_first_toggle", first_toggle_cyc - c0, 35);

    // Fill while paused, 9th push refused
    i_play_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_note(1 + i % 4, 1 + i % 2);
    check("s3_level8", o_level, 8);
    check("s3_ready0", o_ready, 0);
    push_note(5, 1);
    check("s3_level_hold", o_level, 8);

    // Flush during PLAY with queued notes and a simultaneous push
    i_play_en = 1'b1;
    repeat (4) tick();
    check("s5_busy_pre", o_busy, 1);
    clear_trackers();
    i_flush = 1'b1; i_valid = 1'b1; i_half_period = 16'd2; i_dur_ms = 8'd1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    check("s5_level0", o_level, 0); check("s5_idle", o_busy, 0); check("s5_piezo0", o_piezo, 0);
    repeat (5) tick();
    check("s5_no_done", done_cnt, 0);
    check("s5_dropped", o_level, 0);

    // Pause 7 cycles mid-PLAY
    clear_trackers(); c0 = cyc;
    push_note(2, 3);
    repeat (10) tick();
    i_play_en = 1'b0;
    repeat (7) tick();
    i_play_en = 1'b1;
    for (int i = 0; i < 80 && busy_fall_cyc < 0; i++) tick();
    check("s4_busy_fall", busy_fall_cyc - c0, 59);
    check("s4_done_cyc", last_done_cyc - c0, 58);

    // dur=0 note, then reset during the next note's PLAY
    clear_trackers(); c0 = cyc;
    push_note(3, 0);
    push_note(1, 2);
    push_note(4, 1);
    repeat (25) tick();
    check("s6_done_cnt", done_cnt, 1);
    check("s6_first_toggle", first_toggle_cyc - c0, 24);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("s6_piezo", o_piezo, 0); check("s6_busy", o_busy, 0);
    check("s6_done", o_done, 0);   check("s6_level", o_level, 0);
    check("s6_ready", o_ready, 1);
    tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      i_valid       = ($urandom % 3) == 0;
      i_half_period = CNT_W'($urandom_range(0, 5));
      i_dur_ms      = DUR_W'($urandom_range(0, 2));
      i_play_en     = ($urandom % 8) != 0;
      i_flush       = ($urandom % 150) == 0;
      rst           = ($urandom % 400) != 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
